serial_r: RTL and testbench

UART receiver paired with the `serial_s` transmitter: it deserialises an 8N1 asynchronous line (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit) into bytes. It sits directly downstream of the transmitter, with `RDX` wired to the transmitter's `TDX` in loopback benches and to the board RX pin on hardware. Received bytes are presented on a held valid/ack register interface, with framing and overrun reporting.

---
 rtl/serial_r_if.sv | 19 +
 rtl/serial_r.sv | 139 +++++++++++++
 tb/tb_serial_r.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_r_if.sv
// Receive-side handshake bundle for serial_r: held byte/valid with ack, plus status pulses.
interface serial_r_if;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rd_ack,
    output rx_data, rx_valid, frame_err, overrun, busy
  );

  modport slave (
    output rd_ack,
    input  rx_data, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_r.sv
// 8N1 UART receiver: synchronised line, mid-bit sampling, held valid/ack output with
// framing-error and overrun pulses.
//   state   | meaning
//   S_IDLE  | line idle, waiting for rdx_s low
//   S_START | timing to mid start bit to reject glitches
//   S_DATA  | sampling 8 data bits, LSB first, at mid-bit
//   S_STOP  | timing to mid stop bit, deliver byte or flag framing error
//   S_BREAK | line held low after a bad stop, wait for it to return high
module serial_r #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic     m_clock,
  input  logic     p_reset,
  input  logic     RDX,
  serial_r_if.master rx
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_rdx_meta;
  logic          r_rdx_s;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_frame_err;
  logic          r_overrun;
  logic          r_busy;

  assign rx.rx_data   = r_rx_data;
  assign rx.rx_valid  = r_rx_valid;
  assign rx.frame_err = r_frame_err;
  assign rx.overrun   = r_overrun;
  assign rx.busy      = r_busy;

  // Synchroniser resets to the idle-high line level so reset release never looks like a start.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_rdx_meta <= 1'b1;
      r_rdx_s    <= 1'b1;
    end else begin
      r_rdx_meta <= RDX;
      r_rdx_s    <= r_rdx_meta;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (rx.rd_ack && r_rx_valid) r_rx_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_rdx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            if (!r_rdx_s) begin
              r_state   <= S_DATA;
              r_cnt     <= '0;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_shift   <= {r_rdx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (r_rdx_s) begin
              // A coincident ack frees the holding register, so that case is not an overrun.
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_overrun  <= r_rx_valid && !rx.rd_ack;
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (r_rdx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_r.sv
// Directed bench for serial_r at 16 clocks per bit: idle, back-to-back, glitch, framing,
// overrun and mid-frame reset cases with hand-computed expectations.
module tb_serial_r;

  localparam int CPB = 16;
  localparam int LAT = 9 * CPB + CPB / 2 + 3;

  logic m_clock = 1'b0;
  logic p_reset;
  logic RDX;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_busy = 0;
  int   n_ferr = 0;
  int   n_ovr = 0;
  int   t_st[$];

  serial_r_if rx_if ();

  serial_r #(.CLKS_PER_BIT(CPB)) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .RDX     (RDX),
    .rx      (rx_if.master)
  );

  always #5 m_clock = ~m_clock;

  always @(posedge m_clock) cyc <= cyc + 1;

  always @(negedge m_clock) begin
    if (rx_if.busy)      n_busy <= n_busy + 1;
    if (rx_if.frame_err) n_ferr <= n_ferr + 1;
    if (rx_if.overrun)   n_ovr  <= n_ovr + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller must be sitting on a negedge; returns on the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    RDX = 1'b0;
    t_st.push_back(cyc);
    repeat (CPB) @(negedge m_clock);
    for (int i = 0; i < 8; i++) begin
      RDX = d[i];
      repeat (CPB) @(negedge m_clock);
    end
    RDX = stop_bit;
    repeat (CPB) @(negedge m_clock);
  endtask

  task automatic wait_valid(input string tag, output int t_seen);
    bit got = 0;
    t_seen = -1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge m_clock);
      if (rx_if.rx_valid) begin
        got    = 1;
        t_seen = cyc;
      end
    end
    if (!got) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_ack();
    rx_if.rd_ack = 1'b1;
    @(negedge m_clock);
    rx_if.rd_ack = 1'b0;
  endtask

  initial begin
    int b0, f0, o0, tv, lat;
    RDX          = 1'b1;
    rx_if.rd_ack = 1'b0;
    p_reset      = 1'b0;
    repeat (3) @(negedge m_clock);
    p_reset = 1'b1;

    // reset / idle line
    b0 = n_busy;
    repeat (100) @(negedge m_clock);
    check_val("idle_busy_cycles", n_busy - b0, 0);
    check_val("rst_rx_data", rx_if.rx_data, 8'h00);
    check_val("rst_rx_valid", rx_if.rx_valid, 0);
    check_val("rst_frame_err", rx_if.frame_err, 0);
    check_val("rst_overrun", rx_if.overrun, 0);
    check_val("rst_busy", rx_if.busy, 0);

    // back-to-back 0x55, 0xA3
    f0 = n_ferr; o0 = n_ovr;
    t_st.delete();
    fork
      begin
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
      end
      begin
        wait_valid("b2b_55", tv);
        check_val("b2b_data_55", rx_if.rx_data, 8'h55);
        lat = tv - t_st[0];
        check_val("b2b_lat_55", (lat >= LAT - 1 && lat <= LAT + 1), 1);
        pulse_ack();
        check_val("b2b_ack_clears", rx_if.rx_valid, 0);
        wait_valid("b2b_a3", tv);
        check_val("b2b_data_a3", rx_if.rx_data, 8'hA3);
        lat = tv - t_st[1];
        check_val("b2b_lat_a3", (lat >= LAT - 1 && lat <= LAT + 1), 1);
      end
    join
    check_val("b2b_no_ferr", n_ferr - f0, 0);
    check_val("b2b_no_ovr", n_ovr - o0, 0);
    pulse_ack();
    repeat (5) @(negedge m_clock);

    // 4-cycle glitch
    b0 = n_busy;
    RDX = 1'b0;
    repeat (4) @(negedge m_clock);
    RDX = 1'b1;
    repeat (26) @(negedge m_clock);
    check_val("glitch_busy_cycles", n_busy - b0, 8);
    check_val("glitch_busy_end", rx_if.busy, 0);
    check_val("glitch_rx_valid", rx_if.rx_valid, 0);

    // framing error then break, then recovery
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    repeat (3 * CPB) @(negedge m_clock);
    check_val("ferr_pulses", n_ferr - f0, 1);
    check_val("ferr_rx_valid", rx_if.rx_valid, 0);
    check_val("ferr_data_kept", rx_if.rx_data, 8'hA3);
    check_val("ferr_busy_in_break", rx_if.busy, 1);
    RDX = 1'b1;
    repeat (10) @(negedge m_clock);
    check_val("ferr_busy_released", rx_if.busy, 0);
    send_frame(8'h81, 1'b1);
    check_val("after_ferr_valid", rx_if.rx_valid, 1);
    check_val("after_ferr_data", rx_if.rx_data, 8'h81);
    pulse_ack();
    repeat (5) @(negedge m_clock);

    // overrun without ack
    o0 = n_ovr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_val("ovr_pulses", n_ovr - o0, 1);
    check_val("ovr_data", rx_if.rx_data, 8'h22);
    check_val("ovr_valid", rx_if.rx_valid, 1);
    pulse_ack();
    check_val("ovr_ack_clears", rx_if.rx_valid, 0);
    repeat (5) @(negedge m_clock);

    // ack coincident with delivery
    send_frame(8'h11, 1'b1);
    o0 = n_ovr;
    t_st.delete();
    fork
      send_frame(8'h22, 1'b1);
      begin
        bit hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
          @(negedge m_clock);
          if (t_st.size() > 0 && cyc == t_st[0] + LAT - 1) hit = 1;
        end
        check_val("coinc_sync_reached", hit, 1);
        check_val("coinc_pre_valid", rx_if.rx_valid, 1);
        pulse_ack();
        check_val("coinc_valid", rx_if.rx_valid, 1);
        check_val("coinc_data", rx_if.rx_data, 8'h22);
      end
    join
    check_val("coinc_no_ovr", n_ovr - o0, 0);
    pulse_ack();
    repeat (5) @(negedge m_clock);

    // reset during data bit 4 of 0xF0
    f0 = n_ferr; o0 = n_ovr;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge m_clock);
        p_reset = 1'b0;
        @(negedge m_clock);
        check_val("midrst_busy", rx_if.busy, 0);
        repeat (2) @(negedge m_clock);
        p_reset = 1'b1;
      end
    join
    repeat (5) @(negedge m_clock);
    check_val("midrst_rx_valid", rx_if.rx_valid, 0);
    check_val("midrst_rx_data", rx_if.rx_data, 8'h00);
    check_val("midrst_busy_after", rx_if.busy, 0);
    send_frame(8'h0F, 1'b1);
    check_val("midrst_next_valid", rx_if.rx_valid, 1);
    check_val("midrst_next_data", rx_if.rx_data, 8'h0F);
    check_val("midrst_no_ferr", n_ferr - f0, 0);
    check_val("midrst_no_ovr", n_ovr - o0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
